// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - shared helpers and default colours for the layer mixer
package monitor_pkg;

    // Address width able to hold the values 0 .. value-1, never narrower than 1 bit
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Default colours as per-channel saturation patterns {R,G,B}; each set bit
    // expands to an all-ones channel of whatever width the mixer is built with
    typedef logic [2:0] rgb_mask_t;

    localparam rgb_mask_t BLUE   = 3'b001;
    localparam rgb_mask_t GREEN  = 3'b010;
    localparam rgb_mask_t YELLOW = 3'b110;
    localparam rgb_mask_t RED    = 3'b100;
    localparam rgb_mask_t WHITE  = 3'b111;
    localparam rgb_mask_t BLACK  = 3'b000;

    // Channel slice positions inside a packed {R,G,B} palette word
    function automatic int red_lsb(input int color_w);
        return 2 * color_w;
    endfunction

    function automatic int green_lsb(input int color_w);
        return color_w;
    endfunction

    function automatic int blue_lsb(input int color_w);
        return 0;
    endfunction

    // Power-up colour of a palette entry; entry n_layers is the background
    function automatic rgb_mask_t default_mask(input int entry, input int n_layers);
        if (entry == n_layers) begin
            return BLACK;
        end
        case (entry)
            0:       return BLUE;
            1:       return GREEN;
            2:       return YELLOW;
            3:       return RED;
            default: return WHITE;
        endcase
    endfunction

endpackage

// File: rtl/layer_priority_encoder.sv
// rtl/layer_priority_encoder.sv - lowest-index-wins layer selector
module layer_priority_encoder
    import monitor_pkg::*;
#(
    parameter int N_LAYERS = 4
) (
    input  logic [N_LAYERS-1:0]              hit,
    output logic [clog2(N_LAYERS+1)-1:0]     winner
);

    localparam int ID_W = clog2(N_LAYERS + 1);

    // Scan from the lowest-priority layer upward so the lowest set index wins
    always_comb begin
        winner = ID_W'(N_LAYERS);
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/monitor_layer_mixer.sv
// rtl/monitor_layer_mixer.sv - two-stage layer priority, blink and palette compositor
module monitor_layer_mixer
    import monitor_pkg::*;
#(
    parameter int N_LAYERS  = 4,
    parameter int COLOR_W   = 8,
    parameter int FRAME_W   = 6,
    parameter int BLINK_BIT = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_de,
    input  logic [N_LAYERS-1:0]              i_layerHit,
    input  logic                             i_frameStart,
    input  logic [N_LAYERS-1:0]              i_blinkMask,
    input  logic                             i_palWe,
    input  logic [clog2(N_LAYERS+1)-1:0]     i_palAddr,
    input  logic [3*COLOR_W-1:0]             i_palData,
    output logic [COLOR_W-1:0]               o_Red,
    output logic [COLOR_W-1:0]               o_Green,
    output logic [COLOR_W-1:0]               o_Blue,
    output logic                             o_de,
    output logic [clog2(N_LAYERS+1)-1:0]     o_layerId
);

    localparam int ID_W  = clog2(N_LAYERS + 1);
    localparam int PIX_W = 3 * COLOR_W;
    localparam logic [ID_W-1:0] BG_ID = ID_W'(N_LAYERS);

    function automatic logic [PIX_W-1:0] expand(input rgb_mask_t m);
        return {{COLOR_W{m[2]}}, {COLOR_W{m[1]}}, {COLOR_W{m[0]}}};
    endfunction

    logic [FRAME_W-1:0]  frame_cnt;
    logic                blink_phase;
    logic [N_LAYERS-1:0] eff_hit;
    logic [ID_W-1:0]     winner;
    logic                s1_de;
    logic [ID_W-1:0]     s1_id;
    logic [PIX_W-1:0]    palette [N_LAYERS+1];
    logic [PIX_W-1:0]    s2_pix;

    // Phase comes from the pre-increment count, so a pixel sharing a cycle with
    // i_frameStart still sees the old phase
    assign blink_phase = frame_cnt[BLINK_BIT];
    assign eff_hit     = i_layerHit & ~(i_blinkMask & {N_LAYERS{blink_phase}});
    assign s2_pix      = palette[s1_id];

    layer_priority_encoder #(
        .N_LAYERS (N_LAYERS)
    ) u_prio (
        .hit    (eff_hit),
        .winner (winner)
    );

    // Frame counter, wraps naturally at 2^FRAME_W
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt <= '0;
        end else if (i_frameStart) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Palette storage; out-of-range addresses are dropped, reads see the pre-write value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k <= N_LAYERS; k++) begin
                palette[k] <= expand(default_mask(k, N_LAYERS));
            end
        end else if (i_palWe && (32'(i_palAddr) <= 32'(N_LAYERS))) begin
            palette[i_palAddr] <= i_palData;
        end
    end

    // Stage 1: resolve winner and capture display enable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_de <= 1'b0;
            s1_id <= BG_ID;
        end else begin
            s1_de <= i_de;
            s1_id <= winner;
        end
    end

    // Stage 2: palette lookup with blanking outside the active area
    always_ff @(posedge i_clk) begin
        if (i_rst || !s1_de) begin
            o_de      <= 1'b0;
            o_layerId <= BG_ID;
            o_Red     <= '0;
            o_Green   <= '0;
            o_Blue    <= '0;
        end else begin
            o_de      <= 1'b1;
            o_layerId <= s1_id;
            o_Red     <= s2_pix[red_lsb(COLOR_W)   +: COLOR_W];
            o_Green   <= s2_pix[green_lsb(COLOR_W) +: COLOR_W];
            o_Blue    <= s2_pix[blue_lsb(COLOR_W)  +: COLOR_W];
        end
    end

endmodule

// File: tb/tb_monitor_layer_mixer.sv
// tb/tb_monitor_layer_mixer.sv - randomized and directed bench for monitor_layer_mixer
module tb_monitor_layer_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de = 1'b0;
    logic [3:0]  hits = '0;
    logic        fs = 1'b0;
    logic [3:0]  mask = '0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [23:0] data = '0;

    logic [7:0]  o_r, o_g, o_b;
    logic        o_de;
    logic [2:0]  o_id;

    logic        de6 = 1'b0;
    logic [5:0]  hits6 = '0;
    logic [5:0]  zero6 = '0;
    logic        zero1 = 1'b0;
    logic [2:0]  zaddr6 = '0;
    logic [23:0] zdata6 = '0;
    logic [7:0]  o6_r, o6_g, o6_b;
    logic        o6_de;
    logic [2:0]  o6_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    monitor_layer_mixer dut (
        .i_clk(clk), .i_rst(rst), .i_de(de), .i_layerHit(hits), .i_frameStart(fs),
        .i_blinkMask(mask), .i_palWe(we), .i_palAddr(addr), .i_palData(data),
        .o_Red(o_r), .o_Green(o_g), .o_Blue(o_b), .o_de(o_de), .o_layerId(o_id)
    );

    monitor_layer_mixer #(.N_LAYERS(6)) dut6 (
        .i_clk(clk), .i_rst(rst), .i_de(de6), .i_layerHit(hits6), .i_frameStart(zero1),
        .i_blinkMask(zero6), .i_palWe(zero1), .i_palAddr(zaddr6), .i_palData(zdata6),
        .o_Red(o6_r), .o_Green(o6_g), .o_Blue(o6_b), .o_de(o6_de), .o_layerId(o6_id)
    );

    function automatic logic [27:0] pk(input logic d, input logic [2:0] id, input logic [23:0] rgb);
        return {d, id, rgb};
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got de/id/rgb=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference model: frame number, palette contents and a list of pixels in flight
    int          m_frames;
    logic [23:0] m_pal [5];
    logic [27:0] m_exp;
    logic [27:0] m_inflight;
    bit          m_ok = 0;

    function automatic int lowest_set(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[k]) return k;
        end
        return 4;
    endfunction

    task automatic model_defaults();
        m_pal[0] = 24'h0000FF;
        m_pal[1] = 24'h00FF00;
        m_pal[2] = 24'hFFFF00;
        m_pal[3] = 24'hFF0000;
        m_pal[4] = 24'h000000;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_frames   = 0;
            model_defaults();
            m_inflight = pk(1'b0, 3'd4, 24'h0);
            m_exp      = pk(1'b0, 3'd4, 24'h0);
            m_ok       = 1;
        end else begin
            int id;
            bit phase;
            // pixel accepted one edge ago is coloured with the palette as it stands now
            id = int'(m_inflight[26:24]);
            m_exp = m_inflight[27] ? pk(1'b1, 3'(id), m_pal[id]) : pk(1'b0, 3'd4, 24'h0);
            phase = ((m_frames / 16) % 2) == 1;
            m_inflight = pk(de, 3'(lowest_set(hits & ~(phase ? mask : 4'b0000))), 24'h0);
            if (we && int'(addr) <= 4) m_pal[addr] = data;
            if (fs) m_frames = (m_frames + 1) % 64;
        end
    end

    // Compare process: every cycle once the model has been reset
    always @(negedge clk) begin
        if (m_ok) check("pipe", pk(o_de, o_id, {o_r, o_g, o_b}), m_exp);
    end

    initial begin
        repeat (2) tick();
        check("reset4", pk(o_de, o_id, {o_r, o_g, o_b}), 28'h4000000);
        check("reset6", pk(o6_de, o6_id, {o6_r, o6_g, o6_b}), 28'h6000000);

        // first pixel after reset, then a blanked one
        rst = 1'b0; de = 1'b1; hits = 4'b1010;
        de6 = 1'b1; hits6 = 6'b110000;
        tick();
        de = 1'b0;
        tick();
        check("first_green", pk(o_de, o_id, {o_r, o_g, o_b}), 28'h900FF00);
        check("six_layer_white", pk(o6_de, o6_id, {o6_r, o6_g, o6_b}), 28'hCFFFFFF);
        tick();
        check("blanked", pk(o_de, o_id, {o_r, o_g, o_b}), 28'h4000000);

        // back-to-back sweep of every hit pattern
        for (int p = 0; p < 16; p++) begin
            de = 1'b1; hits = 4'(p);
            tick();
        end
        hits = 4'b1100;
        tick(); tick();
        check("yellow_1100", pk(o_de, o_id, {o_r, o_g, o_b}), 28'hAFFFF00);
        hits = 4'b0000;
        tick(); tick();
        check("background", pk(o_de, o_id, {o_r, o_g, o_b}), 28'hC000000);

        // blinking layer 0 over layer 3
        mask = 4'b0001; hits = 4'b1001;
        tick(); tick();
        check("blink_off_blue", pk(o_de, o_id, {o_r, o_g, o_b}), 28'h80000FF);
        fs = 1'b1;
        repeat (16) tick();
        fs = 1'b0;
        tick(); tick();
        check("blink_on_red", pk(o_de, o_id, {o_r, o_g, o_b}), 28'hBFF0000);
        fs = 1'b1;
        repeat (16) tick();
        fs = 1'b0;
        tick(); tick();
        check("blink_wrap_blue", pk(o_de, o_id, {o_r, o_g, o_b}), 28'h80000FF);

        // palette write ordering against lookups
        mask = 4'b0000; hits = 4'b1000;
        tick();
        we = 1'b1; addr = 3'd3; data = 24'h102030;
        tick();
        we = 1'b0;
        check("write_same_cycle_old", pk(o_de, o_id, {o_r, o_g, o_b}), 28'hBFF0000);
        tick();
        check("write_next_cycle_new", pk(o_de, o_id, {o_r, o_g, o_b}), 28'hB102030);
        we = 1'b1; addr = 3'd5; data = 24'h123456;
        tick();
        we = 1'b0;
        tick(); tick();
        check("write_addr5_ignored", pk(o_de, o_id, {o_r, o_g, o_b}), 28'hB102030);

        // reset mid-stream restores palette and frame counter
        we = 1'b1; addr = 3'd0; data = 24'hABCDEF;
        tick();
        we = 1'b0; hits = 4'b0001;
        tick(); tick();
        check("entry0_written", pk(o_de, o_id, {o_r, o_g, o_b}), 28'h8ABCDEF);
        mask = 4'b0001; fs = 1'b1;
        repeat (16) tick();
        fs = 1'b0;
        tick(); tick();
        check("blinked_away", pk(o_de, o_id, {o_r, o_g, o_b}), 28'hC000000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_zero", pk(o_de, o_id, {o_r, o_g, o_b}), 28'h4000000);
        tick(); tick();
        check("after_reset_blue", pk(o_de, o_id, {o_r, o_g, o_b}), 28'h80000FF);

        // randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            de   = ($urandom_range(0, 3) != 0);
            hits = 4'($urandom);
            mask = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
            fs   = ($urandom_range(0, 7) == 0);
            we   = ($urandom_range(0, 3) == 0);
            addr = 3'($urandom);
            data = 24'($urandom);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; we = 1'b0; fs = 1'b0; de = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
